fc_layer_sched: RTL
===================

// Module: fc_layer_sched
// PURPOSE
//  Sequencer for the two fully-connected layers (FC1 then FC2) of the LeNet accelerator.
//  Walks each output neuron over its inputs: act/weight SRAM read addresses, MAC enable/clear strobes.
//  Drives fc_state into fc_quantize; emits aligned write strobe/address for quantized result.
//  FC2 reads FC1 results from the same output buffer, so FC1 fully drains before FC2 starts.
// PARAMETERS
//  FC1_IN   256  FC1 input length (activations per neuron)
//  FC1_OUT  64   FC1 neuron count (= FC2 input length)
//  FC2_OUT  10   FC2 neuron count
//  AW       16   width of act_addr / wgt_addr / out_addr
// PORTS
//  clk        in   1   clock
//  srstn      in   1   synchronous reset, active-low
//  start      in   1   pulse: begin FC1+FC2 run; ignored unless IDLE
//  busy       out  1   high from cycle after accepted start until done pulse inclusive
//  done       out  1   1-cycle pulse after last FC2 result written
//  fc_state   out  1   0 = FC1, 1 = FC2; to fc_quantize and MAC
//  rd_en      out  1   act/weight SRAM read enable
//  act_addr   out  AW  input index i (FC2: index into FC1 result buffer)
//  wgt_addr   out  AW  FC1: o*FC1_IN+i; FC2: FC1_OUT*FC1_IN + o*FC1_OUT + i
//  mac_en     out  1   MAC accumulate this cycle (SRAM data valid)
//  mac_first  out  1   with mac_en: load product, discard old accumulator
//  quant_go   out  1   accumulator holds complete sum; presented to fc_quantize
//  out_we     out  1   quantized_data valid; write to output buffer
//  out_addr   out  AW  neuron index o for out_we (FC2 results at FC1_OUT+o)
// BEHAVIOUR
//  Reset (srstn=0 at posedge): FSM->IDLE, counters 0, every output 0. Applies mid-run: run aborted, no done.
//  FSM: IDLE -start-> FC1 -> DRAIN1 -> FC2 -> DRAIN2 -> DONE -> IDLE.
//   FC1/FC2: one rd_en per cycle, no bubbles; i counts 0..IN-1, then o++, i=0.
//   Leave FC1 after issuing (o=FC1_OUT-1,i=FC1_IN-1); DRAIN1 waits until that neuron's out_we seen.
//   DRAIN2 same for FC2; DONE lasts 1 cycle, drives done=1, then IDLE.
//  fc_state: 0 in IDLE/FC1/DRAIN1, 1 in FC2/DRAIN2/DONE (held through drain so quantizer mode matches).
//  Pipeline (t = cycle rd_en issued for (o,i)):
//   t+1: mac_en=1; mac_first=1 iff i==0 (SRAM 1-cycle read latency)
//   t+2: quant_go=1 iff i==IN-1 (accumulator registered)
//   t+3: out_we=1, out_addr=o (fc_quantize 1-cycle register)
//  Delay pipe carries first/last/o tags; out_addr taken from tag, not live counter.
//  Back-to-back neurons: mac_first of o+1 coincides with quant_go of o; no gap inserted.
//  Per layer: IN*OUT rd_en cycles, OUT out_we pulses. FC1->FC2 gap: 3 cycles of drain.
//  start while busy: ignored. start in the DONE cycle: ignored. Counters never wrap past OUT-1.
//  Address arithmetic unsigned, AW bits; parameters must satisfy all addresses < 2**AW.
// TESTING
//  1. Reset release, idle 10 cycles, no start -> all outputs 0, busy=0.
//  2. Small params (FC1_IN=4,FC1_OUT=3,FC2_OUT=2), start -> 12 FC1 rd_en, wgt_addr 0..11; 6 FC2 rd_en,
//     wgt_addr 12..17; out_addr 0,1,2 then 3,4; done once, 12+3+6+3+1 cycles after start.
//  3. Same run with MAC+fc_quantize model, sums 64*130 (FC1) and -32*200 (FC2) -> writes 127 and -128.
//  4. fc_state transition -> flips 0->1 only after FC1 out_addr 2 written; never during FC1 writes.
//  5. start pulsed again mid-FC1 -> ignored, sequence/count identical to test 2.
//  6. srstn low during FC2 -> next cycle all outputs 0, no done; new start reruns full sequence.

Source files
------------

// File: rtl/fc_layer_sched.sv
// Sequencer for the two fully-connected layers: walks every (neuron, input) pair,
// issues SRAM reads, MAC strobes and the aligned quantized-result write.
module fc_layer_sched #(
    parameter int unsigned FC1_IN  = 256,
    parameter int unsigned FC1_OUT = 64,
    parameter int unsigned FC2_OUT = 10,
    parameter int unsigned AW      = 16
) (
    input  logic          clk,
    input  logic          srstn,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          fc_state,
    output logic          rd_en,
    output logic [AW-1:0] act_addr,
    output logic [AW-1:0] wgt_addr,
    output logic          mac_en,
    output logic          mac_first,
    output logic          quant_go,
    output logic          out_we,
    output logic [AW-1:0] out_addr
);

    localparam logic [AW-1:0] FC1_IN_LAST   = AW'(FC1_IN - 1);
    localparam logic [AW-1:0] FC1_OUT_LAST  = AW'(FC1_OUT - 1);
    localparam logic [AW-1:0] FC2_IN_LAST   = AW'(FC1_OUT - 1);
    localparam logic [AW-1:0] FC2_OUT_LAST  = AW'(FC2_OUT - 1);
    localparam logic [AW-1:0] FC2_OUT_BASE  = AW'(FC1_OUT);
    localparam logic [AW-1:0] FC2_LAST_ADDR = AW'(FC1_OUT + FC2_OUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FC1,
        S_DRAIN1,
        S_FC2,
        S_DRAIN2,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] i_q, i_d;
    logic [AW-1:0] o_q, o_d;
    logic [AW-1:0] wgt_q, wgt_d;

    logic          rd_en_d;
    logic          busy_d;
    logic          done_d;
    logic          fc_state_d;
    logic          last_now;
    logic [AW-1:0] tag_now;

    // Result-pipeline tags: last-input flag and output-buffer address per issued read
    logic          p1_last;
    logic [AW-1:0] p1_tag;
    logic [AW-1:0] p2_tag;

    // Next-state, counter advance and next registered-output values
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        o_d        = o_q;
        wgt_d      = wgt_q;
        rd_en_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        fc_state_d = 1'b0;
        last_now   = 1'b0;
        tag_now    = o_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FC1;
                    i_d     = '0;
                    o_d     = '0;
                    wgt_d   = '0;
                end
            end
            S_FC1: begin
                wgt_d = wgt_q + AW'(1);
                if (i_q == FC1_IN_LAST) begin
                    i_d = '0;
                    if (o_q == FC1_OUT_LAST) begin
                        state_d = S_DRAIN1;
                        o_d     = '0;
                    end else begin
                        o_d = o_q + AW'(1);
                    end
                end else begin
                    i_d = i_q + AW'(1);
                end
            end
            S_DRAIN1: begin
                if (out_we && (out_addr == FC1_OUT_LAST)) begin
                    state_d = S_FC2;
                end
            end
            S_FC2: begin
                // FC2 weights sit directly after FC1's, so the weight pointer just keeps counting
                wgt_d = wgt_q + AW'(1);
                if (i_q == FC2_IN_LAST) begin
                    i_d = '0;
                    if (o_q == FC2_OUT_LAST) begin
                        state_d = S_DRAIN2;
                        o_d     = '0;
                    end else begin
                        o_d = o_q + AW'(1);
                    end
                end else begin
                    i_d = i_q + AW'(1);
                end
            end
            S_DRAIN2: begin
                if (out_we && (out_addr == FC2_LAST_ADDR)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_en_d    = (state_d == S_FC1) || (state_d == S_FC2);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        fc_state_d = (state_d == S_FC2) || (state_d == S_DRAIN2) || (state_d == S_DONE);

        // Tags of the read being issued this cycle (counters track rd_en)
        if (state_q == S_FC2) begin
            last_now = (i_q == FC2_IN_LAST);
            tag_now  = o_q + FC2_OUT_BASE;
        end else begin
            last_now = (i_q == FC1_IN_LAST);
            tag_now  = o_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            o_q     <= '0;
            wgt_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            o_q     <= o_d;
            wgt_q   <= wgt_d;
        end
    end

    // Registered outputs and the read -> MAC -> accumulate -> quantize delay pipe
    always_ff @(posedge clk) begin
        if (!srstn) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            fc_state  <= 1'b0;
            rd_en     <= 1'b0;
            act_addr  <= '0;
            wgt_addr  <= '0;
            mac_en    <= 1'b0;
            mac_first <= 1'b0;
            p1_last   <= 1'b0;
            p1_tag    <= '0;
            quant_go  <= 1'b0;
            p2_tag    <= '0;
            out_we    <= 1'b0;
            out_addr  <= '0;
        end else begin
            busy      <= busy_d;
            done      <= done_d;
            fc_state  <= fc_state_d;
            rd_en     <= rd_en_d;
            act_addr  <= rd_en_d ? i_d : '0;
            wgt_addr  <= rd_en_d ? wgt_d : '0;
            mac_en    <= rd_en;
            mac_first <= rd_en && (i_q == '0);
            p1_last   <= rd_en && last_now;
            p1_tag    <= rd_en ? tag_now : '0;
            quant_go  <= p1_last;
            p2_tag    <= p1_tag;
            out_we    <= quant_go;
            out_addr  <= quant_go ? p2_tag : '0;
        end
    end

endmodule
